// File: rtl/mealy_table_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mealy_table_fsm
// Brief    : Mealy state machine whose next state and output are read from a
//            runtime-writable table indexed by {state, x}.
// Revision : 1.0 - initial release
// ============================================================================
module mealy_table_fsm #(
  parameter int STATE_W     = 2,
  parameter int IN_W        = 1,
  parameter int OUT_W       = 2,
  parameter int REG_OUT     = 0,
  parameter int RESET_STATE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [IN_W-1:0]           x,
  input  logic                      cfg_we,
  input  logic [STATE_W+IN_W-1:0]   cfg_addr,
  input  logic [STATE_W-1:0]        cfg_next,
  input  logic [OUT_W-1:0]          cfg_out,
  input  logic                      err_clr,
  output logic [OUT_W-1:0]          y,
  output logic [STATE_W-1:0]        state,
  output logic [STATE_W-1:0]        next_state,
  output logic                      err
);

  localparam int                 ADDR_W    = STATE_W + IN_W;
  localparam int                 DEPTH     = 1 << ADDR_W;
  localparam logic [STATE_W-1:0] RST_STATE = STATE_W'(RESET_STATE);

  logic [DEPTH-1:0]   valid_q;
  logic [STATE_W-1:0] tbl_next_q [DEPTH];
  logic [OUT_W-1:0]   tbl_out_q  [DEPTH];

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               err_q;
  logic               err_d;

  logic [ADDR_W-1:0]  lut_idx;
  logic               lut_hit;
  logic [OUT_W-1:0]   y_comb;

  assign lut_idx = {state_q, x};
  assign lut_hit = valid_q[lut_idx];

  // Only the valid bits need a reset; stale fields are masked by valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (cfg_we) begin
      valid_q[cfg_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we && !rst) begin
      tbl_next_q[cfg_addr] <= cfg_next;
      tbl_out_q[cfg_addr]  <= cfg_out;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      err_q   <= 1'b0;
    end else begin
      if (en) begin
        state_q <= state_d;
      end
      err_q <= err_d;
    end
  end

  // Next-state logic; an invalid lookup on an enabled edge outranks err_clr.
  always_comb begin
    state_d = RST_STATE;
    if (lut_hit) begin
      state_d = tbl_next_q[lut_idx];
    end
    err_d = (en & ~lut_hit) | (err_q & ~err_clr);
  end

  // Output logic
  always_comb begin
    y_comb = '0;
    if (lut_hit) begin
      y_comb = tbl_out_q[lut_idx];
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [OUT_W-1:0] y_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          y_q <= '0;
        end else if (en) begin
          y_q <= y_comb;
        end
      end
      assign y = y_q;
    end else begin : g_comb_out
      assign y = y_comb;
    end
  endgenerate

  assign state      = state_q;
  assign next_state = state_d;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mealy_table_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mealy_table_fsm
// Brief    : Self-checking bench for mealy_table_fsm, combinational and
//            registered output variants driven by the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mealy_table_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [0:0] x = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [1:0] cfg_next = '0;
  logic [1:0] cfg_out = '0;
  logic       err_clr = 1'b0;

  logic [1:0] y0, st0, ns0;
  logic       err0;
  logic [1:0] y1, st1, ns1;
  logic       err1;

  int checks = 0;
  int errors = 0;

  // Reference model: table as plain arrays, state/err/registered y as ints.
  bit m_valid [8];
  int m_next  [8];
  int m_out   [8];
  int m_state = 0;
  bit m_err   = 0;
  int m_yreg  = 0;

  int img_next [8] = '{0, 2, 0, 1, 1, 0, 3, 3};
  int img_out  [8] = '{1, 0, 0, 1, 2, 0, 2, 0};

  always #5 clk = ~clk;

  mealy_table_fsm #(.REG_OUT(0)) u_comb (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_next(cfg_next), .cfg_out(cfg_out), .err_clr(err_clr),
    .y(y0), .state(st0), .next_state(ns0), .err(err0)
  );

  mealy_table_fsm #(.REG_OUT(1)) u_reg (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_next(cfg_next), .cfg_out(cfg_out), .err_clr(err_clr),
    .y(y1), .state(st1), .next_state(ns1), .err(err1)
  );

  function automatic int m_y();
    int i;
    i = m_state * 2 + int'(x);
    return m_valid[i] ? m_out[i] : 0;
  endfunction

  function automatic int m_ns();
    int i;
    i = m_state * 2 + int'(x);
    return m_valid[i] ? m_next[i] : 0;
  endfunction

  task automatic model_edge();
    int i;
    bit v;
    int o;
    int n;
    i = m_state * 2 + int'(x);
    v = m_valid[i];
    o = m_out[i];
    n = m_next[i];
    if (rst) begin
      m_state = 0;
      m_err   = 0;
      m_yreg  = 0;
      foreach (m_valid[k]) m_valid[k] = 0;
    end else begin
      m_err = (en && !v) || (m_err && !err_clr);
      if (en) begin
        m_yreg  = v ? o : 0;
        m_state = v ? n : 0;
      end
      if (cfg_we) begin
        m_valid[cfg_addr] = 1;
        m_next[cfg_addr]  = int'(cfg_next);
        m_out[cfg_addr]   = int'(cfg_out);
      end
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; en = 0; cfg_we = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    clk_edge();
    rst = 0;
  endtask

  task automatic load_image();
    for (int i = 0; i < 8; i++) begin
      cfg_we   = 1;
      cfg_addr = 3'(i);
      cfg_next = 2'(img_next[i]);
      cfg_out  = 2'(img_out[i]);
      clk_edge();
    end
    cfg_we = 0;
  endtask

  task automatic test_reset();
    do_reset();
    x = 1;
    #1;
    checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", st0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err got %0d want 0", err0); end
    checks++; if (y0 !== 2'd0) begin errors++; $display("FAIL reset_y_comb got %0d want 0", y0); end
    checks++; if (ns0 !== 2'd0) begin errors++; $display("FAIL reset_next got %0d want 0", ns0); end
    checks++; if (y1 !== 2'd0) begin errors++; $display("FAIL reset_y_reg got %0d want 0", y1); end
  endtask

  task automatic test_walk();
    int xs [4] = '{1, 0, 1, 0};
    int es [4] = '{2, 1, 1, 0};
    int ey [4] = '{0, 2, 1, 0};
    do_reset();
    load_image();
    for (int i = 0; i < 4; i++) begin
      x = 1'(xs[i]);
      en = 1;
      #1;
      checks++; if (y0 !== 2'(ey[i])) begin errors++; $display("FAIL walk_y step %0d got %0d want %0d", i, y0, ey[i]); end
      checks++; if (ns0 !== 2'(es[i])) begin errors++; $display("FAIL walk_next step %0d got %0d want %0d", i, ns0, es[i]); end
      clk_edge();
      checks++; if (st0 !== 2'(es[i])) begin errors++; $display("FAIL walk_state step %0d got %0d want %0d", i, st0, es[i]); end
      checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL walk_err step %0d got %0d want 0", i, err0); end
    end
    en = 0;
  endtask

  task automatic test_hold();
    logic [1:0] yr;
    x = 1; en = 1;
    clk_edge();
    en = 0;
    yr = y1;
    for (int i = 0; i < 3; i++) begin
      x = 1'(i[0]);
      #1;
      checks++; if (y0 !== (x ? 2'd0 : 2'd2)) begin errors++; $display("FAIL hold_y_comb x=%0d got %0d want %0d", x, y0, x ? 0 : 2); end
      clk_edge();
      checks++; if (st0 !== 2'd2) begin errors++; $display("FAIL hold_state got %0d want 2", st0); end
      checks++; if (y1 !== yr) begin errors++; $display("FAIL hold_y_reg got %0d want %0d", y1, yr); end
    end
  endtask

  task automatic test_invalid();
    do_reset();
    x = 1; en = 1;
    #1;
    checks++; if (y0 !== 2'd0) begin errors++; $display("FAIL inv_y got %0d want 0", y0); end
    checks++; if (ns0 !== 2'd0) begin errors++; $display("FAIL inv_next got %0d want 0", ns0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL inv_err_early got %0d want 0", err0); end
    clk_edge();
    en = 0;
    checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL inv_state got %0d want 0", st0); end
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL inv_err_set got %0d want 1", err0); end
    err_clr = 1;
    clk_edge();
    err_clr = 0;
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL inv_err_clr got %0d want 0", err0); end
    en = 1;
    clk_edge();
    en = 1; err_clr = 1;
    clk_edge();
    idle_inputs();
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL inv_set_wins got %0d want 1", err0); end
  endtask

  task automatic test_write_collision();
    do_reset();
    load_image();
    x = 1; en = 1;
    cfg_we = 1; cfg_addr = 3'd1; cfg_next = 2'd3; cfg_out = 2'd3;
    #1;
    checks++; if (y0 !== 2'd0) begin errors++; $display("FAIL coll_old_y got %0d want 0", y0); end
    clk_edge();
    cfg_we = 0;
    checks++; if (st0 !== 2'd2) begin errors++; $display("FAIL coll_old_next got %0d want 2", st0); end
    clk_edge();
    checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL coll_return got %0d want 0", st0); end
    #1;
    checks++; if (y0 !== 2'd3) begin errors++; $display("FAIL coll_new_y got %0d want 3", y0); end
    clk_edge();
    en = 0;
    checks++; if (st0 !== 2'd3) begin errors++; $display("FAIL coll_new_state got %0d want 3", st0); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    load_image();
    x = 1; en = 1;
    clk_edge();
    rst = 1; cfg_we = 1; cfg_addr = 3'd1; cfg_next = 2'd3; cfg_out = 2'd3;
    clk_edge();
    rst = 0; cfg_we = 0;
    checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL rmid_state got %0d want 0", st0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL rmid_err got %0d want 0", err0); end
    #1;
    checks++; if (ns0 !== 2'd0) begin errors++; $display("FAIL rmid_dropped_next got %0d want 0", ns0); end
    checks++; if (y0 !== 2'd0) begin errors++; $display("FAIL rmid_dropped_y got %0d want 0", y0); end
    clk_edge();
    en = 0;
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL rmid_err_after got %0d want 1", err0); end
  endtask

  task automatic test_reg_out();
    int xs [4] = '{1, 0, 1, 0};
    int ey [4] = '{0, 2, 1, 0};
    logic [1:0] yr;
    do_reset();
    checks++; if (y1 !== 2'd0) begin errors++; $display("FAIL reg_reset_y got %0d want 0", y1); end
    load_image();
    checks++; if (y1 !== 2'd0) begin errors++; $display("FAIL reg_load_y got %0d want 0", y1); end
    for (int i = 0; i < 4; i++) begin
      yr = y1;
      x = 1'(xs[i]); en = 1;
      #1;
      checks++; if (y1 !== yr) begin errors++; $display("FAIL reg_between step %0d got %0d want %0d", i, y1, yr); end
      clk_edge();
      checks++; if (y1 !== 2'(ey[i])) begin errors++; $display("FAIL reg_walk_y step %0d got %0d want %0d", i, y1, ey[i]); end
    end
    en = 0;
    for (int i = 0; i < 3; i++) begin
      x = 1'(i[0]);
      clk_edge();
      checks++; if (y1 !== 2'd0) begin errors++; $display("FAIL reg_hold_y got %0d want 0", y1); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 39) == 0);
      en       = $urandom_range(0, 1) == 1;
      x        = 1'($urandom_range(0, 1));
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_addr = 3'($urandom_range(0, 7));
      cfg_next = 2'($urandom_range(0, 3));
      cfg_out  = 2'($urandom_range(0, 3));
      err_clr  = ($urandom_range(0, 7) == 0);
      #1;
      checks++; if (y0 !== 2'(m_y())) begin errors++; $display("FAIL rnd_y_comb cyc %0d got %0d want %0d", i, y0, m_y()); end
      checks++; if (ns0 !== 2'(m_ns())) begin errors++; $display("FAIL rnd_next cyc %0d got %0d want %0d", i, ns0, m_ns()); end
      clk_edge();
      checks++; if (st0 !== 2'(m_state) || st1 !== 2'(m_state)) begin errors++; $display("FAIL rnd_state cyc %0d got %0d/%0d want %0d", i, st0, st1, m_state); end
      checks++; if (err0 !== m_err || err1 !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %0d/%0d want %0d", i, err0, err1, m_err); end
      checks++; if (y1 !== 2'(m_yreg)) begin errors++; $display("FAIL rnd_y_reg cyc %0d got %0d want %0d", i, y1, m_yreg); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_walk();
    test_hold();
    test_invalid();
    test_write_collision();
    test_reset_midrun();
    test_reg_out();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
